// File: rtl/spi_master_param.sv
// spi_master_param: parameterised SPI master that shifts out one
// {addr,data} frame per rising edge of cfg_apply, MSB first.
// Optional MISO readback into rd_data: define SPI_READBACK_EN.
module spi_master_param #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 4,
  parameter int CLK_DIV = 1,
  parameter int CPOL    = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cfg_apply,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              spi_miso,
  output logic              spi_clk,
  output logic              spi_csn,
  output logic              spi_mosi,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data
);

  localparam int         FRAME_W  = ADDR_W + DATA_W;
  localparam logic       CLK_IDLE = (CPOL != 0);
  localparam logic [7:0] DIV_M1   = 8'(CLK_DIV - 1);
  localparam logic [4:0] LAST_BIT = 5'(FRAME_W - 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t             state;
  logic [1:0]         sync;
  logic               prev;
  logic [2:0]         fill;
  logic               start;
  logic [7:0]         cnt;
  logic [4:0]         bit_idx;
  logic               lead;
  logic [FRAME_W-1:0] shreg;
`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0]  rx;
`endif

  // Synchronise cfg_apply and turn its rising edge into a one-cycle start pulse.
  // prev holds a genuine post-reset sample only from the third edge on, so
  // fill gates the detector and a level held high through reset never fires.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync  <= '0;
      prev  <= 1'b0;
      fill  <= '0;
      start <= 1'b0;
    end else begin
      sync  <= {sync[0], cfg_apply};
      prev  <= sync[1];
      fill  <= {fill[1:0], 1'b1};
      start <= sync[1] & ~prev & fill[2];
    end
  end

  // Frame sequencer: IDLE -> SETUP -> XFER (lead/trail halves) -> HOLD -> IDLE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      lead     <= 1'b0;
      shreg    <= '0;
      spi_csn  <= 1'b1;
      spi_clk  <= CLK_IDLE;
      spi_mosi <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef SPI_READBACK_EN
      rx       <= '0;
      rd_data  <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= SETUP;
            cnt      <= DIV_M1;
            shreg    <= {cfg_addr, cfg_data};
            spi_mosi <= cfg_addr[ADDR_W-1];
            spi_csn  <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            state   <= XFER;
            cnt     <= DIV_M1;
            lead    <= 1'b1;
            bit_idx <= '0;
            spi_clk <= ~CLK_IDLE;
`ifdef SPI_READBACK_EN
            rx      <= DATA_W'({rx, spi_miso});
`endif
          end
        end
        XFER: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (lead) begin
            lead    <= 1'b0;
            cnt     <= DIV_M1;
            spi_clk <= CLK_IDLE;
            if (bit_idx != LAST_BIT) begin
              shreg    <= {shreg[FRAME_W-2:0], 1'b0};
              spi_mosi <= shreg[FRAME_W-2];
            end
          end else if (bit_idx == LAST_BIT) begin
            state <= HOLD;
            cnt   <= DIV_M1;
          end else begin
            lead    <= 1'b1;
            cnt     <= DIV_M1;
            bit_idx <= bit_idx + 5'd1;
            spi_clk <= ~CLK_IDLE;
`ifdef SPI_READBACK_EN
            rx      <= DATA_W'({rx, spi_miso});
`endif
          end
        end
        HOLD: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            state    <= IDLE;
            spi_csn  <= 1'b1;
            spi_mosi <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
`ifdef SPI_READBACK_EN
            rd_data  <= rx;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SPI_READBACK_EN
  logic unused_miso;
  assign unused_miso = spi_miso;
  assign rd_data     = '0;
`endif

endmodule
